// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - four-entry fetch-to-decode instruction queue
// Circular buffer of {pc, instr, adel}; head is presented to decode, flush empties it in one cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushD,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    input  logic             push_adel,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [31:0]      instrD,
    output logic [31:0]      pcD,
    output logic             adelD,
    output logic [PTR_W:0]   countD,
    output logic             almost_fullD
);

    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   AF_LVL   = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic             adel_mem_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic             push_fire;
    logic             pop_fire;

    // Handshake flags come from count_q only, so no input reaches an output combinationally.
    always_comb begin
        push_ready = (count_q != FULL_LVL);
        pop_valid  = (count_q != '0);
        push_fire  = push_valid & push_ready & ~flushD;
        pop_fire   = pop_valid & pop_ready & ~flushD;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot contents are never cleared; validity is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem_q[wr_ptr_q]    <= push_pc;
            instr_mem_q[wr_ptr_q] <= push_instr;
            adel_mem_q[wr_ptr_q]  <= push_adel;
        end
    end

    // Empty queue shows a nop at pc 0 so decode raises nothing.
    always_comb begin
        instrD       = pop_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
        pcD          = pop_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
        adelD        = pop_valid ? adel_mem_q[rd_ptr_q]  : 1'b0;
        countD       = count_q;
        almost_fullD = (count_q >= AF_LVL);
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushD;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_adel;
    logic        push_ready;
    logic        pop_ready;
    logic        pop_valid;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        adelD;
    logic [2:0]  countD;
    logic        almost_fullD;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flushD       (flushD),
        .push_valid   (push_valid),
        .push_pc      (push_pc),
        .push_instr   (push_instr),
        .push_adel    (push_adel),
        .push_ready   (push_ready),
        .pop_ready    (pop_ready),
        .pop_valid    (pop_valid),
        .instrD       (instrD),
        .pcD          (pcD),
        .adelD        (adelD),
        .countD       (countD),
        .almost_fullD (almost_fullD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ad, input logic pr, input logic fl);
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        push_adel  = ad;
        pop_ready  = pr;
        flushD     = fl;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic [31:0] ins, input logic ad);
        ent_t e;
        e.pc    = pc;
        e.instr = ins;
        e.adel  = ad;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every head the DUT hands to decode must be the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && pop_valid && pop_ready && !flushD) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: popped pc %h with no expected entry", pcD);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("head_pc", pcD, e.pc);
                chk("head_instr", instrD, e.instr);
                chk("head_adel", {31'b0, adelD}, {31'b0, e.adel});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_pop_valid", {31'b0, pop_valid}, 32'd0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_adelD", {31'b0, adelD}, 32'd0);
        chk("rst_countD", {29'b0, countD}, 32'd0);
        chk("rst_push_ready", {31'b0, push_ready}, 32'd1);
        chk("rst_almost_full", {31'b0, almost_fullD}, 32'd0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hBFC00000 + 32'(4 * i), 32'h24080001 + 32'(i), 1'b0, 1'b0, 1'b0);
            expect_push(32'hBFC00000 + 32'(4 * i), 32'h24080001 + 32'(i), 1'b0);
            step();
            chk("fill_count", {29'b0, countD}, 32'(i + 1));
            chk("fill_almost_full", {31'b0, almost_fullD}, (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_push_ready", {31'b0, push_ready}, (i + 1 < 4) ? 32'd1 : 32'd0);
        end
        chk("full_head_pc", pcD, 32'hBFC00000);
        drive(1'b1, 32'hBFC00010, 32'h24080005, 1'b0, 1'b0, 1'b0);
        step();
        chk("hold5_count_a", {29'b0, countD}, 32'd4);
        chk("hold5_ready_a", {31'b0, push_ready}, 32'd0);
        step();
        chk("hold5_count_b", {29'b0, countD}, 32'd4);

        // Drain two to reach count 2.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("to2_count", {29'b0, countD}, 32'd2);
        chk("to2_head_pc", pcD, 32'hBFC00008);

        // Simultaneous push and pop at count 2.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'hBFC00010 + 32'(4 * k), 32'h24080005 + 32'(k), 1'b0, 1'b1, 1'b0);
            expect_push(32'hBFC00010 + 32'(4 * k), 32'h24080005 + 32'(k), 1'b0);
            step();
            chk("pp_count", {29'b0, countD}, 32'd2);
            chk("pp_head_pc", pcD, 32'hBFC0000C + 32'(4 * k));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("pp_drained", {29'b0, countD}, 32'd0);

        // Wrap-around: nine pushes with decode always ready.
        for (int k = 0; k < 9; k++) begin
            logic [31:0] pc;
            pc = (k == 4) ? 32'hBFC00001 : 32'h90000000 + 32'(4 * k);
            drive(1'b1, pc, 32'hA0000000 + 32'(k), (k == 4), 1'b1, 1'b0);
            expect_push(pc, 32'hA0000000 + 32'(k), (k == 4));
            step();
            chk("wrap_count", {29'b0, countD}, 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        chk("wrap_drained", {29'b0, countD}, 32'd0);

        // Flush at count 3 with a concurrent push and pop request.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h80000100 + 32'(4 * i), 32'hC0000000 + 32'(i), 1'b0, 1'b0, 1'b0);
            expect_push(32'h80000100 + 32'(4 * i), 32'hC0000000 + 32'(i), 1'b0);
            step();
        end
        chk("pre_flush_count", {29'b0, countD}, 32'd3);
        drive(1'b1, 32'h80000180, 32'h00000000, 1'b0, 1'b1, 1'b1);
        sb.delete();
        step();
        chk("flush_count", {29'b0, countD}, 32'd0);
        chk("flush_pop_valid", {31'b0, pop_valid}, 32'd0);
        chk("flush_pcD", pcD, 32'h0);
        drive(1'b1, 32'h80000180, 32'h00000000, 1'b0, 1'b0, 1'b0);
        expect_push(32'h80000180, 32'h00000000, 1'b0);
        step();
        chk("post_flush_valid", {31'b0, pop_valid}, 32'd1);
        chk("post_flush_pc", pcD, 32'h80000180);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        chk("post_flush_drained", {29'b0, countD}, 32'd0);

        // Full, then pop only.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h00001000 + 32'(4 * i), 32'hD0000000 + 32'(i), 1'b0, 1'b0, 1'b0);
            expect_push(32'h00001000 + 32'(4 * i), 32'hD0000000 + 32'(i), 1'b0);
            step();
        end
        chk("full2_count", {29'b0, countD}, 32'd4);
        chk("full2_ready", {31'b0, push_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        chk("poponly_count", {29'b0, countD}, 32'd3);
        chk("poponly_ready", {31'b0, push_ready}, 32'd1);
        chk("poponly_head", pcD, 32'h00001004);

        // Asynchronous reset between edges at count 3.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_pop_valid", {31'b0, pop_valid}, 32'd0);
        chk("arst_count", {29'b0, countD}, 32'd0);
        chk("arst_push_ready", {31'b0, push_ready}, 32'd1);
        chk("arst_almost_full", {31'b0, almost_fullD}, 32'd0);
        chk("arst_instrD", instrD, 32'h0);
        chk("arst_pcD", pcD, 32'h0);
        chk("arst_adelD", {31'b0, adelD}, 32'd0);
        step();
        rst = 1'b0;
        step();

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
